fb_read_scanner: RTL and testbench
==================================

# fb_read_scanner

Read-side raster scanner for the pseudo-sensor frame buffer. It walks a synchronous-read frame-buffer RAM in linear raster order and issues one read per active pixel, with programmable horizontal and vertical blanking. It realigns the returned RAM data into a pixel stream with start-of-frame and end-of-line markers. It sits between the frame-buffer RAM read port and the downstream LeNet-5 input or display path, mirroring the linear write addressing used on the sensor side.

## Interface
- ADDR_WIDTH, 19: read address width; must hold H_ACTIVE*V_ACTIVE-1.
- DATA_WIDTH, 8: pixel width.
- H_ACTIVE, 640: active pixels per line.
- H_BLANK, 160: blank cycles per line, ≥1.
- V_ACTIVE, 480: active lines per frame.
- V_BLANK, 45: blank lines per frame, ≥0.
- RD_LATENCY, 1: RAM read latency in cycles, from address to data; range 1..4.

Ports:
- p_clk  in  1  pixel clock; all logic on the rising edge.
- arst_p_n  in  1  asynchronous active-low reset.
- enable  in  1  scan request; sampled only at frame boundaries.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_WIDTH  RAM read address, valid when rd_en=1.
- rd_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after rd_en.
- pix_de  out  1  output pixel valid.
- pix_sof  out  1  first pixel of the frame; coincides with pix_de.
- pix_eol  out  1  last pixel of a line; coincides with pix_de.
- pix_data  out  DATA_WIDTH  output pixel; zero when pix_de=0.
- busy  out  1  high while in SCAN.

## Operation
- The state machine has two states, IDLE and SCAN.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE + H_BLANK.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE + V_BLANK.
  - rd_addr is a registered counter.
- IDLE:
  - Counters and rd_addr are held at 0.
  - On an edge where enable=1, go to SCAN.
- SCAN:
  - h_cnt increments every cycle.
  - When h_cnt reaches H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
- rd_en = (state==SCAN) & (h_cnt<H_ACTIVE) & (v_cnt<V_ACTIVE). It is combinational from registers.
- rd_addr increments by 1 on every cycle with rd_en=1. It returns to 0 at each frame start.
- Frame end is the cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1:
  - If enable=1: counters and rd_addr wrap to 0 and the block stays in SCAN. Frames run back-to-back with no gap.
  - If enable=0: go to IDLE.
- Deasserting enable mid-frame has no effect until frame end. The current frame always completes, including blanking.
- Flag pipeline:
  - Flags computed on the rd_en cycle: de, sof (h_cnt=0 and v_cnt=0), and eol (h_cnt=H_ACTIVE-1).
  - The flags are delayed by a RD_LATENCY-stage shift register.
  - At the last stage, rd_data is registered together with the flags into pix_*.
- Address arithmetic is unsigned modulo 2^ADDR_WIDTH. Wrap cannot occur for legal parameters.

## Timing
- Reset values:
  - State IDLE; h_cnt, v_cnt, rd_addr = 0.
  - rd_en = 0, busy = 0.
  - pix_de, pix_sof, pix_eol = 0; pix_data = 0.
  - The flag pipeline is cleared.
- Reset asserted mid-frame aborts immediately. After release the block behaves exactly as from power-up and requires enable again.
- Start: on edge N, enable=1 in IDLE moves the block to SCAN. rd_en=1 with rd_addr=0 in cycle N+1.
- Latency: a rd_en in cycle k produces its pix_de in cycle k+RD_LATENCY+1, with pix_data equal to RAM[rd_addr of cycle k].
- Outputs per frame:
  - rd_en is high for exactly H_ACTIVE*V_ACTIVE cycles.
  - rd_en is high for H_ACTIVE consecutive cycles per active line.
  - The last address in a frame is H_ACTIVE*V_ACTIVE-1.
- In steady SCAN, busy=1 continuously. busy drops on the edge after the frame-end cycle when enable=0.
- After return to IDLE, the earliest next frame start is 1 cycle later, when enable is sampled high.
- There is no backpressure. Downstream must accept every pix_de.

## Test plan
Small parameters: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, RD_LATENCY=1, RAM model returns data = addr+8'h10.
- Single frame:
  - Stimulus: pulse enable for 1 cycle.
  - rd_addr must run 0..11 in 3 bursts of 4, each burst followed by 2 idle cycles.
  - pix_de follows each rd_en 2 cycles later with pix_data 0x10..0x1B.
  - pix_sof is high only with data 0x10. pix_eol is high with 0x13, 0x17 and 0x1B.
  - busy is high for 24 cycles, then the block returns to IDLE.
- Continuous: hold enable=1 for 3 frames.
  - Frames are 24 cycles apart with no gap.
  - rd_addr restarts at 0 each frame.
  - 3 pix_sof pulses, 36 pix_de total.
- Enable dropped mid-frame:
  - Stimulus: deassert enable at cycle 5 of a frame.
  - The frame completes with all 12 reads, then IDLE. No second frame starts.
- Reset mid-frame:
  - Stimulus: assert arst_p_n=0 during line 1.
  - All outputs go to 0 immediately, including the in-flight pix_de.
  - After release with enable=1, the frame restarts at rd_addr=0 with pix_sof.
- Latency sweep:
  - Stimulus: RD_LATENCY=3 with a matching RAM model.
  - pix_de must appear 4 cycles after rd_en, and the data values must be unchanged.

Source files
------------

// File: rtl/fb_read_scanner.sv
// Raster read scanner: walks a synchronous-read frame buffer in linear order with
// programmable blanking and realigns returned RAM data into a flagged pixel stream.
module fb_read_scanner #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_BLANK    = 160,
    parameter int V_ACTIVE   = 480,
    parameter int V_BLANK    = 45,
    parameter int RD_LATENCY = 1
) (
    input  logic                  p_clk,
    input  logic                  arst_p_n,
    input  logic                  enable,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  pix_de,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  busy
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_EOL  = H_W'(H_ACTIVE - 1);
    localparam logic [H_W-1:0] H_ONE  = H_W'(1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_ONE  = V_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]            state;
    logic [H_W-1:0]        h_cnt;
    logic [V_W-1:0]        v_cnt;
    logic [RD_LATENCY-1:0] de_pipe;
    logic [RD_LATENCY-1:0] sof_pipe;
    logic [RD_LATENCY-1:0] eol_pipe;

    assign rd_en = (state == S_SCAN) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign busy  = (state == S_SCAN);

    // Enable is only consulted in IDLE and at the last blanking cycle of a frame.
    always_ff @(posedge p_clk or negedge arst_p_n) begin
        if (!arst_p_n) begin
            state   <= S_IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            rd_addr <= '0;
        end else if (state == S_IDLE) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            rd_addr <= '0;
            if (enable) begin
                state <= S_SCAN;
            end
        end else begin
            if (rd_en) begin
                rd_addr <= rd_addr + ADDR_ONE;
            end
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt   <= '0;
                    rd_addr <= '0;
                    if (!enable) begin
                        state <= S_IDLE;
                    end
                end else begin
                    v_cnt <= v_cnt + V_ONE;
                end
            end else begin
                h_cnt <= h_cnt + H_ONE;
            end
        end
    end

    // Flags travel alongside the RAM read so they meet rd_data at the last stage.
    always_ff @(posedge p_clk or negedge arst_p_n) begin
        if (!arst_p_n) begin
            de_pipe  <= '0;
            sof_pipe <= '0;
            eol_pipe <= '0;
            pix_de   <= 1'b0;
            pix_sof  <= 1'b0;
            pix_eol  <= 1'b0;
            pix_data <= '0;
        end else begin
            de_pipe[0]  <= rd_en;
            sof_pipe[0] <= rd_en && (h_cnt == '0) && (v_cnt == '0);
            eol_pipe[0] <= rd_en && (h_cnt == H_EOL);
            for (int i = 1; i < RD_LATENCY; i++) begin
                de_pipe[i]  <= de_pipe[i-1];
                sof_pipe[i] <= sof_pipe[i-1];
                eol_pipe[i] <= eol_pipe[i-1];
            end
            pix_de   <= de_pipe[RD_LATENCY-1];
            pix_sof  <= sof_pipe[RD_LATENCY-1];
            pix_eol  <= eol_pipe[RD_LATENCY-1];
            pix_data <= de_pipe[RD_LATENCY-1] ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_fb_read_scanner.sv
// Scoreboard bench for fb_read_scanner: two instances (read latency 1 and 3) share
// stimulus; a frame-position model predicts reads and queues the expected pixels.
module tb_fb_read_scanner;

    localparam int H_ACT = 4;
    localparam int H_BLK = 2;
    localparam int V_ACT = 3;
    localparam int V_BLK = 1;
    localparam int H_TOT = H_ACT + H_BLK;
    localparam int FRAME = H_TOT * (V_ACT + V_BLK);
    localparam int AW    = 19;
    localparam int DW    = 8;

    typedef struct {
        logic [DW-1:0] data;
        bit            sof;
        bit            eol;
        int            due;
    } pix_t;

    logic p_clk    = 1'b0;
    logic arst_p_n = 1'b0;
    logic enable   = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   base_de [2];
    int   base_sof[2];

    always #5 p_clk = ~p_clk;

    always @(posedge p_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int lat, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (RD_LATENCY=%0d) at %0t: got 0x%0h, expected 0x%0h",
                     name, lat, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        logic          rd_en, pix_de, pix_sof, pix_eol, busy;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] rd_data, pix_data;
        logic [DW-1:0] ram_pipe[LAT];
        pix_t          q[$];
        int            t         = 0;
        bit            scan      = 0;
        int            de_count  = 0;
        int            sof_count = 0;

        fb_read_scanner #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .H_ACTIVE(H_ACT), .H_BLANK(H_BLK),
            .V_ACTIVE(V_ACT), .V_BLANK(V_BLK), .RD_LATENCY(LAT)
        ) dut (
            .p_clk(p_clk), .arst_p_n(arst_p_n), .enable(enable), .rd_en(rd_en),
            .rd_addr(rd_addr), .rd_data(rd_data), .pix_de(pix_de), .pix_sof(pix_sof),
            .pix_eol(pix_eol), .pix_data(pix_data), .busy(busy)
        );

        // RAM returns addr+0x10 after LAT cycles; junk when nothing was read.
        assign rd_data = ram_pipe[LAT-1];
        always @(posedge p_clk) begin
            ram_pipe[0] <= rd_en ? DW'(rd_addr + 'h10) : DW'($urandom);
            for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
        end

        // Model: position t within the frame, or idle.
        always @(posedge p_clk or negedge arst_p_n) begin
            if (!arst_p_n) begin
                scan = 0;
                t    = 0;
            end else if (!scan) begin
                if (enable) begin
                    scan = 1;
                    t    = 0;
                end
            end else if (t == FRAME - 1) begin
                if (enable) t = 0;
                else scan = 0;
            end else begin
                t++;
            end
        end

        always @(negedge p_clk) begin : monitor
            bit   exp_rd, due_now;
            int   addr;
            pix_t p, e;
            if (!arst_p_n) begin
                q.delete();
                checkOutput("reset rd_en", LAT, 32'(rd_en), 0);
                checkOutput("reset busy", LAT, 32'(busy), 0);
                checkOutput("reset rd_addr", LAT, 32'(rd_addr), 0);
                checkOutput("reset pix_de", LAT, 32'(pix_de), 0);
                checkOutput("reset pix_sof", LAT, 32'(pix_sof), 0);
                checkOutput("reset pix_eol", LAT, 32'(pix_eol), 0);
                checkOutput("reset pix_data", LAT, 32'(pix_data), 0);
            end else begin
                exp_rd = scan && ((t % H_TOT) < H_ACT) && ((t / H_TOT) < V_ACT);
                checkOutput("rd_en", LAT, 32'(rd_en), 32'(exp_rd));
                checkOutput("busy", LAT, 32'(busy), 32'(scan));
                if (exp_rd) begin
                    addr = (t / H_TOT) * H_ACT + (t % H_TOT);
                    checkOutput("rd_addr", LAT, 32'(rd_addr), addr);
                    p.data = DW'(addr + 'h10);
                    p.sof  = (t == 0);
                    p.eol  = ((t % H_TOT) == H_ACT - 1);
                    p.due  = cyc + LAT + 1;
                    q.push_back(p);
                end
                due_now = (q.size() != 0) && (q[0].due == cyc);
                checkOutput("pix_de timing", LAT, 32'(pix_de), 32'(due_now));
                if (pix_de) begin
                    de_count++;
                    if (pix_sof) sof_count++;
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        checkOutput("pix_data", LAT, 32'(pix_data), 32'(e.data));
                        checkOutput("pix_sof", LAT, 32'(pix_sof), 32'(e.sof));
                        checkOutput("pix_eol", LAT, 32'(pix_eol), 32'(e.eol));
                    end
                end else begin
                    checkOutput("idle pix_data", LAT, 32'(pix_data), 0);
                    checkOutput("idle pix_sof", LAT, 32'(pix_sof), 0);
                    checkOutput("idle pix_eol", LAT, 32'(pix_eol), 0);
                    if (due_now) void'(q.pop_front());
                end
            end
        end
    end

    // Holds enable at en for exactly n sampling edges.
    task automatic applyStimulus(input bit en, input int n);
        @(posedge p_clk);
        #2 enable = en;
        repeat (n - 1) @(posedge p_clk);
    endtask

    task automatic markCounts();
        base_de[0]  = g_inst[0].de_count;
        base_sof[0] = g_inst[0].sof_count;
        base_de[1]  = g_inst[1].de_count;
        base_sof[1] = g_inst[1].sof_count;
    endtask

    task automatic checkCounts(input string name, input int de_exp, input int sof_exp);
        checkOutput({name, " pix_de count"}, 1, g_inst[0].de_count - base_de[0], de_exp);
        checkOutput({name, " pix_sof count"}, 1, g_inst[0].sof_count - base_sof[0], sof_exp);
        checkOutput({name, " pix_de count"}, 3, g_inst[1].de_count - base_de[1], de_exp);
        checkOutput({name, " pix_sof count"}, 3, g_inst[1].sof_count - base_sof[1], sof_exp);
    endtask

    initial begin
        repeat (3) @(posedge p_clk);
        #2 arst_p_n = 1'b1;

        $display("[TB] single frame");
        markCounts();
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 40);
        checkCounts("single", 12, 1);

        $display("[TB] three back-to-back frames");
        markCounts();
        applyStimulus(1'b1, 3 * FRAME);
        applyStimulus(1'b0, 40);
        checkCounts("continuous", 36, 3);

        $display("[TB] enable dropped mid-frame");
        markCounts();
        applyStimulus(1'b1, 5);
        applyStimulus(1'b0, 40);
        checkCounts("drop", 12, 1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 9);
        @(posedge p_clk);
        #2 arst_p_n = 1'b0;
        #1;
        checkOutput("async pix_de", 1, 32'(g_inst[0].pix_de), 0);
        checkOutput("async rd_en", 1, 32'(g_inst[0].rd_en), 0);
        checkOutput("async busy", 1, 32'(g_inst[0].busy), 0);
        checkOutput("async pix_de", 3, 32'(g_inst[1].pix_de), 0);
        checkOutput("async rd_en", 3, 32'(g_inst[1].rd_en), 0);
        checkOutput("async busy", 3, 32'(g_inst[1].busy), 0);
        repeat (2) @(posedge p_clk);
        #2 arst_p_n = 1'b1;
        markCounts();
        applyStimulus(1'b0, 40);
        checkCounts("after reset", 12, 1);

        $display("[TB] random enable");
        repeat (300) applyStimulus($urandom_range(0, 3) != 0, 1);
        applyStimulus(1'b0, 40);

        checkOutput("scoreboard drained", 1, g_inst[0].q.size(), 0);
        checkOutput("scoreboard drained", 3, g_inst[1].q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
